// File: rtl/fix_uart_scheduler.sv
// Streams each accepted GPS fix as "LAT:...,N LON:...,E\r\n" over a shared uart_tx.
// Handles fix decimation, one-deep pending restart and overrun reporting.
module fix_uart_scheduler #(
    parameter int FIX_DIVIDE = 1,
    parameter bit SEND_CRLF  = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        new_fix,
    input  logic [79:0] lat_bus,
    input  logic [3:0]  lat_len,
    input  logic        lat_dir,
    input  logic [87:0] lon_bus,
    input  logic [3:0]  lon_len,
    input  logic        lon_dir,
    input  logic        tx_busy,
    output logic [7:0]  tx_data,
    output logic        tx_start,
    output logic        busy,
    output logic        fix_dropped
);
    typedef enum logic [1:0] {IDLE, EMIT, ACK, WAIT} state_t;

    state_t      state, state_n;
    logic [5:0]  idx, idx_n;
    logic [7:0]  div_cnt;
    logic        pending, pending_n;
    logic        load, start_n, drop_n, accept;
    logic [7:0]  data_n, byte_sel;
    logic [79:0] lat_r;
    logic [87:0] lon_r;
    logic [3:0]  lat_l, lon_l;
    logic        lat_d, lon_d;
    logic [5:0]  lat_end, lon_beg, lon_end, last_idx;
    logic [5:0]  lat_off, lon_off, sep_off;

    assign accept = new_fix && (div_cnt == 8'd0);
    assign busy   = (state != IDLE);

    // Byte positions are relative to the end of each variable-length digit run.
    always_comb begin
        lat_end  = 6'd4 + 6'(lat_l);
        lon_beg  = lat_end + 6'd7;
        lon_end  = lon_beg + 6'(lon_l);
        last_idx = lon_end + (SEND_CRLF ? 6'd3 : 6'd1);
        lat_off  = idx - 6'd4;
        lon_off  = idx - lon_beg;
        sep_off  = idx - lat_end;
        byte_sel = 8'h00;
        if (idx < 6'd4) begin
            case (idx[1:0])
                2'd0:    byte_sel = "L";
                2'd1:    byte_sel = "A";
                2'd2:    byte_sel = "T";
                default: byte_sel = ":";
            endcase
        end else if (idx < lat_end) begin
            byte_sel = lat_r[{lat_off[3:0], 3'b000} +: 8];
        end else if (idx < lon_beg) begin
            case (sep_off)
                6'd0:    byte_sel = ",";
                6'd1:    byte_sel = lat_d ? "N" : "S";
                6'd2:    byte_sel = " ";
                6'd3:    byte_sel = "L";
                6'd4:    byte_sel = "O";
                6'd5:    byte_sel = "N";
                default: byte_sel = ":";
            endcase
        end else if (idx < lon_end) begin
            byte_sel = lon_r[{lon_off[3:0], 3'b000} +: 8];
        end else if (idx == lon_end) begin
            byte_sel = ",";
        end else if (idx == lon_end + 6'd1) begin
            byte_sel = lon_d ? "E" : "W";
        end else if (idx == lon_end + 6'd2) begin
            byte_sel = 8'h0D;
        end else begin
            byte_sel = 8'h0A;
        end
    end

    always_comb begin
        state_n   = state;
        idx_n     = idx;
        pending_n = pending;
        load      = 1'b0;
        start_n   = 1'b0;
        data_n    = tx_data;
        drop_n    = 1'b0;
        if (accept && state != IDLE) begin
            if (pending) drop_n = 1'b1;
            else         pending_n = 1'b1;
        end
        case (state)
            IDLE: begin
                if (accept) begin
                    load    = 1'b1;
                    idx_n   = 6'd0;
                    state_n = EMIT;
                end
            end
            EMIT: begin
                if (!tx_busy) begin
                    start_n = 1'b1;
                    data_n  = byte_sel;
                    state_n = ACK;
                end
            end
            ACK: state_n = WAIT;
            WAIT: begin
                if (!tx_busy) begin
                    if (idx == last_idx) begin
                        // Parser holds its last fix, so the live inputs are the newest one.
                        if (pending_n) begin
                            load      = 1'b1;
                            pending_n = 1'b0;
                            idx_n     = 6'd0;
                            state_n   = EMIT;
                        end else begin
                            state_n = IDLE;
                        end
                    end else begin
                        idx_n   = idx + 6'd1;
                        state_n = EMIT;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            idx         <= 6'd0;
            pending     <= 1'b0;
            div_cnt     <= 8'd0;
            tx_start    <= 1'b0;
            tx_data     <= 8'h00;
            fix_dropped <= 1'b0;
        end else begin
            state       <= state_n;
            idx         <= idx_n;
            pending     <= pending_n;
            tx_start    <= start_n;
            tx_data     <= data_n;
            fix_dropped <= drop_n;
            if (new_fix)
                div_cnt <= (div_cnt == 8'(FIX_DIVIDE - 1)) ? 8'd0 : div_cnt + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (load) begin
            lat_r <= lat_bus;
            lon_r <= lon_bus;
            lat_l <= (lat_len > 4'd10) ? 4'd10 : lat_len;
            lon_l <= (lon_len > 4'd11) ? 4'd11 : lon_len;
            lat_d <= lat_dir;
            lon_d <= lon_dir;
        end
    end
endmodule
